// File: rtl/fpu_muldiv_seq.sv
// fpu_muldiv_seq: multi-cycle signed/unsigned multiply and restoring divide, one bit per clock.
// Optional MULDIV_EARLY_OUT_EN lets multiplies leave RUN once no multiplier bits remain.
module fpu_muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       FPUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] F_hi,
  output logic [WIDTH-1:0] F_lo,
  output logic             div_by_zero,
  output logic             illegal_op
);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_div, r_neg_q, r_neg_r;
  logic [2*WIDTH-1:0] r_p, r_m;
  logic [WIDTH-1:0]   r_b;
  logic               w_accept, w_ill, w_dbz, w_sgn, w_early, w_last, w_ge;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_quo, w_rem, w_hi, w_lo;
  logic [WIDTH:0]     w_t, w_diff;
  logic [2*WIDTH-1:0] w_mul_p, w_div_p, w_prod;
  assign w_accept = (r_state == IDLE) && start;
  assign w_ill    = FPUOp[2];
  assign w_dbz    = ~FPUOp[2] & FPUOp[1] & (B == '0);
  assign w_sgn    = ~FPUOp[0];
  assign w_a_mag  = (w_sgn && A[WIDTH-1]) ? -A : A;
  assign w_b_mag  = (w_sgn && B[WIDTH-1]) ? -B : B;
  // r_p holds the running product, or {remainder, dividend/quotient} when dividing
  assign w_mul_p  = r_b[0] ? r_p + r_m : r_p;
  assign w_t      = r_p[2*WIDTH-1:WIDTH-1];
  assign w_diff   = w_t - {1'b0, r_m[WIDTH-1:0]};
  assign w_ge     = ~w_diff[WIDTH];
  assign w_div_p  = {w_ge ? w_diff[WIDTH-1:0] : w_t[WIDTH-1:0], r_p[WIDTH-2:0], w_ge};
  assign w_prod   = r_neg_q ? -r_p : r_p;
  assign w_quo    = r_neg_q ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
  assign w_rem    = r_neg_r ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];
  assign w_hi     = r_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
  assign w_lo     = r_div ? w_quo : w_prod[WIDTH-1:0];
`ifdef MULDIV_EARLY_OUT_EN
  assign w_early  = ~r_div && (r_b[WIDTH-1:1] == '0);
`else
  assign w_early  = 1'b0;
`endif
  assign w_last   = (r_cnt == CNT_W'(1)) || w_early;
  always_ff @(posedge clk)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = !start ? IDLE : (w_ill || w_dbz) ? DONE : RUN;
      RUN:     w_next = w_last ? FIX : RUN;
      FIX:     w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    busy = (r_state == RUN) || (r_state == FIX);
    done = (r_state == DONE);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_div       <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_p         <= '0;
      r_m         <= '0;
      r_b         <= '0;
      F_hi        <= '0;
      F_lo        <= '0;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_div       <= FPUOp[1];
        r_neg_q     <= w_sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
        r_neg_r     <= w_sgn & A[WIDTH-1];
        r_cnt       <= CNT_W'(WIDTH);
        r_p         <= FPUOp[1] ? {{WIDTH{1'b0}}, w_a_mag} : '0;
        r_m         <= {{WIDTH{1'b0}}, FPUOp[1] ? w_b_mag : w_a_mag};
        r_b         <= w_b_mag;
        div_by_zero <= w_dbz;
        illegal_op  <= w_ill;
        if (w_ill || w_dbz) begin
          F_hi <= w_ill ? '0 : A;
          F_lo <= w_ill ? '0 : '1;
        end
      end
      if (r_state == RUN) begin
        r_cnt <= r_cnt - 1'b1;
        r_p   <= r_div ? w_div_p : w_mul_p;
        r_m   <= r_div ? r_m : r_m << 1;
        r_b   <= r_b >> 1;
      end
      if (r_state == FIX) begin
        F_hi <= w_hi;
        F_lo <= w_lo;
      end
    end
  end
endmodule

// File: tb/tb_fpu_muldiv_seq.sv
// tb_fpu_muldiv_seq: directed and random checks of fpu_muldiv_seq against a 64-bit arithmetic model.
module tb_fpu_muldiv_seq;
  localparam int W = 32;
  logic clk = 0, rst_n = 0, start = 0;
  logic [2:0] op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, div_by_zero, illegal_op;
  logic [W-1:0] f_hi, f_lo;
  int n_chk = 0, n_err = 0;

  fpu_muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .FPUOp(op), .A(a), .B(b),
    .busy(busy), .done(done), .F_hi(f_hi), .F_lo(f_lo),
    .div_by_zero(div_by_zero), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic [2:0] o, input logic [W-1:0] bb);
    logic [W-1:0] m;
    int h;
    if (o[2] || (o[1] && bb == '0)) return 1;
    m = (!o[0] && bb[W-1]) ? -bb : bb;
    h = 0;
    for (int i = 0; i < W; i++) if (m[i]) h = i;
`ifdef MULDIV_EARLY_OUT_EN
    if (!o[1]) return 3 + h;
`endif
    return W + 2;
  endfunction

  // returns {illegal, div_by_zero, hi, lo}
  function automatic logic [65:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sa, sb, sp, sq, sr;
    logic [63:0] ua, ub, up;
    sa = $signed(x);
    sb = $signed(y);
    ua = {32'b0, x};
    ub = {32'b0, y};
    if (o[2]) return {2'b10, 64'b0};
    if (o[1] && y == '0) return {2'b01, x, 32'hFFFF_FFFF};
    case (o[1:0])
      2'b00: begin sp = sa * sb; return {2'b00, sp}; end
      2'b01: begin up = ua * ub; return {2'b00, up}; end
      2'b10: begin sq = sa / sb; sr = sa % sb; return {2'b00, sr[31:0], sq[31:0]}; end
      default: begin up = ua / ub; ua = ua % ub; return {2'b00, ua[31:0], up[31:0]}; end
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [65:0] e;
    int n, lat;
    e = model(o, x, y);
    lat = exp_lat(o, y);
    @(negedge clk);
    start = 1; op = o; a = x; b = y;
    @(negedge clk);
    start = 0; a = $urandom; b = $urandom; op = 3'($urandom);
    n = 1;
    if (lat > 1) chk({tag, " busy"}, 64'(busy), 64'd1);
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(lat));
    chk({tag, " hi"}, 64'(f_hi), 64'(e[63:32]));
    chk({tag, " lo"}, 64'(f_lo), 64'(e[31:0]));
    chk({tag, " flags"}, 64'({illegal_op, div_by_zero}), 64'(e[65:64]));
  endtask

  initial begin
    int n, dones, n_done, busy_after, lat;
    logic [2:0] o;
    logic [W-1:0] x, y;
    repeat (3) @(negedge clk);
    chk("reset outs", {busy, done, div_by_zero, illegal_op}, 4'b0);
    chk("reset data", {f_hi, f_lo}, 64'b0);
    rst_n = 1;
    run_op("multu", 3'b001, 32'd678, 32'd4293);
    run_op("mult neg neg", 3'b000, -32'sd67, -32'sd93);
    run_op("mult pos neg", 3'b000, 32'd7, -32'sd7);
    run_op("multu big", 3'b001, 32'd7, 32'hFFFF_FFF9);
    run_op("divu", 3'b011, 32'd4293, 32'd678);
    run_op("div neg", 3'b010, -32'sd93, 32'd7);
    run_op("div minint", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div zero", 3'b010, 32'd55, 32'd0);
    run_op("illegal", 3'b101, 32'd12, 32'd34);
    run_op("multu small", 3'b001, 32'd678, 32'd5);
    run_op("mult zero", 3'b000, 32'd1234, 32'd0);
    run_op("mult minint", 3'b000, 32'h8000_0000, 32'h8000_0000);
    // extra start pulses mid-flight and in the DONE cycle must be ignored
    lat = exp_lat(3'b001, 32'd4293);
    @(negedge clk);
    start = 1; op = 3'b001; a = 32'd678; b = 32'd4293;
    @(negedge clk);
    start = 0;
    dones = 0; n_done = 0; busy_after = 0;
    for (n = 1; n < 60; n++) begin
      if (dones > 0 && busy) busy_after = 1;
      if (done) begin dones++; n_done = n; end
      start = (n == 5) || done;
      if (n == 5) begin op = 3'b011; a = 32'd9; b = 32'd3; end
      @(negedge clk);
    end
    start = 0;
    chk("hs done count", 64'(dones), 64'd1);
    chk("hs done cycle", 64'(n_done), 64'(lat));
    chk("hs result", 64'(f_lo), 64'd2910654);
    chk("hs no restart", 64'(busy_after), 64'd0);
    // reset mid-operation
    @(negedge clk);
    start = 1; op = 3'b011; a = 32'd1000; b = 32'd7;
    @(negedge clk);
    start = 0;
    repeat (9) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst outs", {done, div_by_zero, illegal_op}, 3'b0);
    chk("rst data", {f_hi, f_lo}, 64'b0);
    rst_n = 1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("rst no done", 64'(dones), 64'd0);
    for (int k = 0; k < 60; k++) begin
      n = $urandom_range(0, 9);
      o = n < 8 ? 3'(n % 4) : 3'(4 + $urandom_range(0, 3));
      x = $urandom;
      y = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) y = '0;
      if ($urandom_range(0, 9) == 0) x = 32'h8000_0000;
      if ($urandom_range(0, 9) == 0) y = 32'hFFFF_FFFF;
      run_op($sformatf("rand%0d op%0d", k, o), o, x, y);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
